// File: rtl/csr_reg_pkg.sv
// Shared CSR addresses, field positions, write masks and small helpers for the
// machine-mode CSR file and its 64-bit counters.
package csr_reg_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIE_MSIE     = 3;
   localparam int MIE_MTIE     = 7;
   localparam int MIE_MEIE     = 11;

   localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
   localparam logic [31:0] MSTATUS_MPP   = 32'h0000_1800;
   localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;

   // Counter slots: index 0 is mcycle, index 1 is minstret.
   localparam int NUM_CNT = 2;
   localparam logic [11:0] CNT_LO_ADDR [NUM_CNT] = '{CSR_MCYCLE,  CSR_MINSTRET};
   localparam logic [11:0] CNT_HI_ADDR [NUM_CNT] = '{CSR_MCYCLEH, CSR_MINSTRETH};

   typedef struct packed {
      logic hi;
      logic lo;
   } half_we_t;

   function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
      logic [31:0] v;
      v = MSTATUS_MPP;
      v[MSTATUS_MIE]  = mie;
      v[MSTATUS_MPIE] = mpie;
      return v;
   endfunction

endpackage

// File: rtl/csr_reg_if.sv
// Trap/CSR interface between the pipeline controller (master) and the CSR file
// (slave); carries ID read, EX write and trap side-effect signals.
interface csr_reg_if;
   logic [11:0] id_csr_raddr_i;
   logic [31:0] csr_rdata_o;
   logic        csr_illegal_o;
   logic        ex_csr_we_i;
   logic [11:0] ex_csr_waddr_i;
   logic [31:0] ex_csr_wdata_i;
   logic        instret_inc_i;
   logic        irq_software_i;
   logic        irq_timer_i;
   logic        irq_external_i;
   logic        cause_type_i;
   logic        set_cause_i;
   logic [3:0]  trap_casue_i;
   logic        set_mepc_i;
   logic [31:0] mepc_i;
   logic        set_mtval_i;
   logic [31:0] mtval_i;
   logic        mstatus_mie_clear_i;
   logic        mstatus_mie_set_i;
   logic        mstatus_mie_o;
   logic        mie_external_o;
   logic        mie_timer_o;
   logic        mie_sw_o;
   logic        mip_external_o;
   logic        mip_timer_o;
   logic        mip_sw_o;
   logic [31:0] mtvec_o;
   logic [31:0] mepc_o;

   modport slave (
      input  id_csr_raddr_i, ex_csr_we_i, ex_csr_waddr_i, ex_csr_wdata_i,
      input  instret_inc_i, irq_software_i, irq_timer_i, irq_external_i,
      input  cause_type_i, set_cause_i, trap_casue_i, set_mepc_i, mepc_i,
      input  set_mtval_i, mtval_i, mstatus_mie_clear_i, mstatus_mie_set_i,
      output csr_rdata_o, csr_illegal_o, mstatus_mie_o,
      output mie_external_o, mie_timer_o, mie_sw_o,
      output mip_external_o, mip_timer_o, mip_sw_o, mtvec_o, mepc_o
   );

   modport master (
      output id_csr_raddr_i, ex_csr_we_i, ex_csr_waddr_i, ex_csr_wdata_i,
      output instret_inc_i, irq_software_i, irq_timer_i, irq_external_i,
      output cause_type_i, set_cause_i, trap_casue_i, set_mepc_i, mepc_i,
      output set_mtval_i, mtval_i, mstatus_mie_clear_i, mstatus_mie_set_i,
      input  csr_rdata_o, csr_illegal_o, mstatus_mie_o,
      input  mie_external_o, mie_timer_o, mie_sw_o,
      input  mip_external_o, mip_timer_o, mip_sw_o, mtvec_o, mepc_o
   );
endinterface

// File: rtl/csr_reg_counter64.sv
// 64-bit counter with increment enable; a write to either half replaces that
// half and suppresses the increment for that cycle.
module csr_counter64
   import csr_reg_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inc_i,
   input  half_we_t    we_i,
   input  logic [31:0] wdata_i,
   output logic [63:0] count_o
);

   logic [63:0] count_q;
   logic [63:0] count_d;

   always_comb begin
      count_d = count_q;
      if (we_i.lo) begin
         count_d[31:0] = wdata_i;
      end else if (we_i.hi) begin
         count_d[63:32] = wdata_i;
      end else if (inc_i) begin
         count_d = count_q + 64'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/csr_reg.sv
// Machine-mode CSR register file: combinational ID reads with EX bypass,
// single-cycle EX writes, and trap side effects commanded by the controller.
module csr_reg
   import csr_reg_pkg::*;
#(
   parameter logic [31:0] HART_ID     = 32'h0,
   parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
   parameter logic [31:0] MTVEC_RESET = 32'h0
) (
   input logic     clk,
   input logic     rst,
   csr_reg_if.slave bus
);

   logic        mie_q, mie_d;
   logic        mpie_q, mpie_d;
   logic        msie_q, msie_d;
   logic        mtie_q, mtie_d;
   logic        meie_q, meie_d;
   logic [2:0]  mip_q;
   logic [29:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [29:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mtval_q, mtval_d;

   logic [31:0] wdata;
   logic        wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;

   assign wdata       = bus.ex_csr_wdata_i;
   assign wr_mstatus  = bus.ex_csr_we_i && (bus.ex_csr_waddr_i == CSR_MSTATUS);
   assign wr_mie      = bus.ex_csr_we_i && (bus.ex_csr_waddr_i == CSR_MIE);
   assign wr_mtvec    = bus.ex_csr_we_i && (bus.ex_csr_waddr_i == CSR_MTVEC);
   assign wr_mscratch = bus.ex_csr_we_i && (bus.ex_csr_waddr_i == CSR_MSCRATCH);
   assign wr_mepc     = bus.ex_csr_we_i && (bus.ex_csr_waddr_i == CSR_MEPC);
   assign wr_mcause   = bus.ex_csr_we_i && (bus.ex_csr_waddr_i == CSR_MCAUSE);
   assign wr_mtval    = bus.ex_csr_we_i && (bus.ex_csr_waddr_i == CSR_MTVAL);

   // Trap commands outrank EX writes; clear (trap entry) outranks set (mret).
   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      msie_d     = msie_q;
      mtie_d     = mtie_q;
      meie_d     = meie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;

      if (bus.mstatus_mie_clear_i) begin
         mpie_d = mie_q;
         mie_d  = 1'b0;
      end else if (bus.mstatus_mie_set_i) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end else if (wr_mstatus) begin
         mie_d  = wdata[MSTATUS_MIE];
         mpie_d = wdata[MSTATUS_MPIE];
      end

      if (wr_mie) begin
         msie_d = wdata[MIE_MSIE];
         mtie_d = wdata[MIE_MTIE];
         meie_d = wdata[MIE_MEIE];
      end

      if (wr_mtvec)    mtvec_d    = wdata[31:2];
      if (wr_mscratch) mscratch_d = wdata;

      if (bus.set_mepc_i)   mepc_d = bus.mepc_i[31:2];
      else if (wr_mepc)     mepc_d = wdata[31:2];

      if (bus.set_cause_i)  mcause_d = {bus.cause_type_i, 27'b0, bus.trap_casue_i};
      else if (wr_mcause)   mcause_d = wdata;

      if (bus.set_mtval_i)  mtval_d = bus.mtval_i;
      else if (wr_mtval)    mtval_d = wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         msie_q     <= 1'b0;
         mtie_q     <= 1'b0;
         meie_q     <= 1'b0;
         mip_q      <= '0;
         mtvec_q    <= MTVEC_RESET[31:2];
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         msie_q     <= msie_d;
         mtie_q     <= mtie_d;
         meie_q     <= meie_d;
         mip_q      <= {bus.irq_external_i, bus.irq_timer_i, bus.irq_software_i};
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
      end
   end

   logic [63:0]    cnt_val [NUM_CNT];
   logic [NUM_CNT-1:0] cnt_inc;

   assign cnt_inc = {bus.instret_inc_i, 1'b1};

   generate
      for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
         half_we_t cnt_we;
         assign cnt_we.lo = bus.ex_csr_we_i && (bus.ex_csr_waddr_i == CNT_LO_ADDR[gi]);
         assign cnt_we.hi = bus.ex_csr_we_i && (bus.ex_csr_waddr_i == CNT_HI_ADDR[gi]);

         csr_counter64 u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc_i   (cnt_inc[gi]),
            .we_i    (cnt_we),
            .wdata_i (wdata),
            .count_o (cnt_val[gi])
         );
      end
   endgenerate

   logic [31:0] mip_word, mie_word;
   logic [31:0] rd_stored, rd_bypass, rdata;
   logic        rd_writable, rd_illegal;

   always_comb begin
      mip_word = '0;
      mip_word[MIE_MSIE] = mip_q[0];
      mip_word[MIE_MTIE] = mip_q[1];
      mip_word[MIE_MEIE] = mip_q[2];
      mie_word = '0;
      mie_word[MIE_MSIE] = msie_q;
      mie_word[MIE_MTIE] = mtie_q;
      mie_word[MIE_MEIE] = meie_q;
   end

   // rd_bypass is the value a same-cycle EX write to this address would store.
   always_comb begin
      rd_stored   = '0;
      rd_bypass   = wdata;
      rd_writable = 1'b1;
      rd_illegal  = 1'b0;
      case (bus.id_csr_raddr_i)
         CSR_MSTATUS: begin
            rd_stored = mstatus_pack(mie_q, mpie_q);
            rd_bypass = (wdata & MSTATUS_WMASK) | MSTATUS_MPP;
         end
         CSR_MISA: begin
            rd_stored   = MISA_VALUE;
            rd_writable = 1'b0;
         end
         CSR_MIE: begin
            rd_stored = mie_word;
            rd_bypass = wdata & MIE_WMASK;
         end
         CSR_MTVEC: begin
            rd_stored = {mtvec_q, 2'b00};
            rd_bypass = {wdata[31:2], 2'b00};
         end
         CSR_MSCRATCH:  rd_stored = mscratch_q;
         CSR_MEPC: begin
            rd_stored = {mepc_q, 2'b00};
            rd_bypass = {wdata[31:2], 2'b00};
         end
         CSR_MCAUSE:    rd_stored = mcause_q;
         CSR_MTVAL:     rd_stored = mtval_q;
         CSR_MIP: begin
            rd_stored   = mip_word;
            rd_writable = 1'b0;
         end
         CSR_MCYCLE:    rd_stored = cnt_val[0][31:0];
         CSR_MINSTRET:  rd_stored = cnt_val[1][31:0];
         CSR_MCYCLEH:   rd_stored = cnt_val[0][63:32];
         CSR_MINSTRETH: rd_stored = cnt_val[1][63:32];
         CSR_MHARTID: begin
            rd_stored   = HART_ID;
            rd_writable = 1'b0;
         end
         default: begin
            rd_writable = 1'b0;
            rd_illegal  = 1'b1;
         end
      endcase

      if (rd_writable && bus.ex_csr_we_i && (bus.ex_csr_waddr_i == bus.id_csr_raddr_i)) begin
         rdata = rd_bypass;
      end else begin
         rdata = rd_stored;
      end
   end

   assign bus.csr_rdata_o    = rdata;
   assign bus.csr_illegal_o  = rd_illegal;
   assign bus.mstatus_mie_o  = mie_q;
   assign bus.mie_external_o = meie_q;
   assign bus.mie_timer_o    = mtie_q;
   assign bus.mie_sw_o       = msie_q;
   assign bus.mip_external_o = mip_q[2];
   assign bus.mip_timer_o    = mip_q[1];
   assign bus.mip_sw_o       = mip_q[0];
   assign bus.mtvec_o        = {mtvec_q, 2'b00};
   assign bus.mepc_o         = {mepc_q, 2'b00};

endmodule

// File: tb/tb_csr_reg.sv
// Directed bench for csr_reg: hand-computed expectations checked with
// immediate assertions, one line per transaction.
module tb_csr_reg;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   csr_reg_if bus ();

   csr_reg #(
      .HART_ID     (32'h0),
      .MISA_VALUE  (32'h4000_0100),
      .MTVEC_RESET (32'h80)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-18s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      bus.id_csr_raddr_i = addr;
      #1;
      chk(tag, bus.csr_rdata_o, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ex_wr(input logic [11:0] addr, input logic [31:0] data);
      bus.ex_csr_we_i    = 1'b1;
      bus.ex_csr_waddr_i = addr;
      bus.ex_csr_wdata_i = data;
   endtask

   task automatic ex_idle();
      bus.ex_csr_we_i    = 1'b0;
      bus.ex_csr_waddr_i = 12'h000;
      bus.ex_csr_wdata_i = 32'h0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bus.id_csr_raddr_i      = 12'h000;
      bus.instret_inc_i       = 1'b0;
      bus.irq_software_i      = 1'b0;
      bus.irq_timer_i         = 1'b0;
      bus.irq_external_i      = 1'b0;
      bus.cause_type_i        = 1'b0;
      bus.set_cause_i         = 1'b0;
      bus.trap_casue_i        = 4'h0;
      bus.set_mepc_i          = 1'b0;
      bus.mepc_i              = 32'h0;
      bus.set_mtval_i         = 1'b0;
      bus.mtval_i             = 32'h0;
      bus.mstatus_mie_clear_i = 1'b0;
      bus.mstatus_mie_set_i   = 1'b0;
      ex_idle();
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      rd("rst_mtvec", 12'h305, 32'h80);
      chk("rst_mtvec_o", bus.mtvec_o, 32'h80);
      rd("rst_mstatus", 12'h300, 32'h1800);
      chk("rst_illegal_300", {31'b0, bus.csr_illegal_o}, 32'h0);
      rd("rst_unimpl_7c0", 12'h7C0, 32'h0);
      chk("illegal_7c0", {31'b0, bus.csr_illegal_o}, 32'h1);
      chk("rst_mie_o", {31'b0, bus.mstatus_mie_o}, 32'h0);
      chk("rst_mepc_o", bus.mepc_o, 32'h0);
      rd("rst_minstret", 12'hB02, 32'h0);
      rd("misa", 12'h301, 32'h4000_0100);
      rd("mhartid", 12'hF14, 32'h0);

      // minstret counts five retirements
      bus.instret_inc_i = 1'b1;
      repeat (5) tick();
      bus.instret_inc_i = 1'b0;
      rd("minstret_5", 12'hB02, 32'd5);
      rd("minstreth_0", 12'hB82, 32'd0);

      // mstatus / mie writes with masking and bypass
      ex_wr(12'h300, 32'hFFFF_FFFF);
      rd("byp_mstatus", 12'h300, 32'h1888);
      tick();
      ex_wr(12'h304, 32'hFFFF_FFFF);
      rd("byp_mie", 12'h304, 32'h888);
      tick();
      ex_wr(12'h343, 32'h1234_5678);
      tick();
      ex_idle();
      rd("mstatus_wr", 12'h300, 32'h1888);
      rd("mie_wr", 12'h304, 32'h888);
      rd("mtval_wr", 12'h343, 32'h1234_5678);
      chk("mstatus_mie_o", {31'b0, bus.mstatus_mie_o}, 32'h1);
      chk("mie_bits_o", {29'b0, bus.mie_external_o, bus.mie_timer_o, bus.mie_sw_o}, 32'h7);

      // mip latency
      bus.irq_timer_i = 1'b1;
      #1;
      chk("mip_timer_pre", {31'b0, bus.mip_timer_o}, 32'h0);
      tick();
      chk("mip_timer_post", {31'b0, bus.mip_timer_o}, 32'h1);
      rd("mip_read", 12'h344, 32'h80);
      bus.irq_timer_i = 1'b0;

      // Trap entry
      bus.mstatus_mie_clear_i = 1'b1;
      bus.set_cause_i  = 1'b1;
      bus.cause_type_i = 1'b1;
      bus.trap_casue_i = 4'h7;
      bus.set_mepc_i   = 1'b1;
      bus.mepc_i       = 32'h103;
      bus.set_mtval_i  = 1'b1;
      bus.mtval_i      = 32'h0;
      #1;
      chk("trap_no_comb", {31'b0, bus.mstatus_mie_o}, 32'h1);
      tick();
      bus.mstatus_mie_clear_i = 1'b0;
      bus.set_cause_i = 1'b0;
      bus.set_mepc_i  = 1'b0;
      bus.set_mtval_i = 1'b0;
      rd("trap_mcause", 12'h342, 32'h8000_0007);
      rd("trap_mepc", 12'h341, 32'h100);
      chk("trap_mepc_o", bus.mepc_o, 32'h100);
      rd("trap_mtval", 12'h343, 32'h0);
      rd("trap_mstatus", 12'h300, 32'h1880);
      chk("trap_mie_o", {31'b0, bus.mstatus_mie_o}, 32'h0);

      // mret
      bus.mstatus_mie_set_i = 1'b1;
      tick();
      bus.mstatus_mie_set_i = 1'b0;
      rd("mret_mstatus", 12'h300, 32'h1888);

      // Trap clear beats same-cycle EX write
      ex_wr(12'h300, 32'h0);
      bus.mstatus_mie_clear_i = 1'b1;
      tick();
      ex_idle();
      bus.mstatus_mie_clear_i = 1'b0;
      rd("clr_vs_ex", 12'h300, 32'h1880);

      // Clear wins over set
      bus.mstatus_mie_set_i = 1'b1;
      tick();
      rd("set_again", 12'h300, 32'h1888);
      bus.mstatus_mie_clear_i = 1'b1;
      tick();
      bus.mstatus_mie_clear_i = 1'b0;
      bus.mstatus_mie_set_i   = 1'b0;
      rd("clr_wins_set", 12'h300, 32'h1880);

      // mscratch bypass
      ex_wr(12'h340, 32'hDEAD_BEEF);
      rd("byp_mscratch", 12'h340, 32'hDEAD_BEEF);
      tick();
      ex_idle();
      rd("mscratch", 12'h340, 32'hDEAD_BEEF);

      // mepc alignment, trap load beats EX write
      ex_wr(12'h341, 32'h207);
      rd("byp_mepc", 12'h341, 32'h204);
      tick();
      rd("mepc_ex", 12'h341, 32'h204);
      ex_wr(12'h341, 32'h300);
      bus.set_mepc_i = 1'b1;
      bus.mepc_i     = 32'h55;
      tick();
      ex_idle();
      bus.set_mepc_i = 1'b0;
      rd("mepc_trap_win", 12'h341, 32'h54);

      // mcause full write, mtvec alignment
      ex_wr(12'h342, 32'hFFFF_FFFF);
      tick();
      ex_wr(12'h305, 32'h1003);
      tick();
      ex_idle();
      rd("mcause_full", 12'h342, 32'hFFFF_FFFF);
      rd("mtvec_align", 12'h305, 32'h1000);
      chk("mtvec_o", bus.mtvec_o, 32'h1000);

      // Read-only and unimplemented writes ignored
      ex_wr(12'h301, 32'h0);
      rd("misa_byp_ro", 12'h301, 32'h4000_0100);
      tick();
      ex_wr(12'h7C0, 32'hFFFF_FFFF);
      rd("unimpl_byp", 12'h7C0, 32'h0);
      tick();
      ex_idle();
      rd("misa_ro", 12'h301, 32'h4000_0100);

      // mcycle low/high writes and carry
      ex_wr(12'hB00, 32'hFFFF_FFFF);
      tick();
      ex_wr(12'hB80, 32'h0);
      tick();
      ex_idle();
      rd("mcycle_hold", 12'hB00, 32'hFFFF_FFFF);
      rd("mcycleh_wr", 12'hB80, 32'h0);
      tick();
      rd("mcycle_wrap", 12'hB00, 32'h0);
      rd("mcycleh_carry", 12'hB80, 32'h1);

      // minstret write suppresses same-cycle increment
      bus.instret_inc_i = 1'b1;
      ex_wr(12'hB02, 32'd10);
      tick();
      ex_idle();
      rd("minstret_wr", 12'hB02, 32'd10);
      tick();
      rd("minstret_inc", 12'hB02, 32'd11);

      // Reset mid-count overrides writes and traps
      ex_wr(12'h340, 32'h1111_2222);
      bus.mstatus_mie_set_i = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ex_idle();
      bus.mstatus_mie_set_i = 1'b0;
      bus.instret_inc_i     = 1'b0;
      rd("rst2_minstret", 12'hB02, 32'h0);
      rd("rst2_mcycle", 12'hB00, 32'h0);
      rd("rst2_mcycleh", 12'hB80, 32'h0);
      rd("rst2_mscratch", 12'h340, 32'h0);
      rd("rst2_mstatus", 12'h300, 32'h1800);
      chk("rst2_mtvec_o", bus.mtvec_o, 32'h80);
      chk("rst2_mepc_o", bus.mepc_o, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/csr_reg.md
Name: csr_reg

Overview:
- Machine-mode CSR register file. It is the responder end of the trap/CSR interface driven by the pipeline controller (ctrl).
- Serves combinational CSR reads to the ID stage and takes single-cycle CSR writes from the EX stage.
- Applies trap side effects commanded by ctrl: cause, mepc, mtval, and mstatus.MIE set/clear.
- Returns interrupt-enable, pending, mtvec and mepc state to ctrl.

Parameters:
- HART_ID, 32'h0, value returned by mhartid.
- MISA_VALUE, 32'h40000100, value returned by misa (RV32I).
- MTVEC_RESET, 32'h0, mtvec reset value; bits [1:0] are ignored.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- id_csr_raddr_i  in  12  read address from ID
- csr_rdata_o  out  32  read data to ID, combinational
- csr_illegal_o  out  1  read address is not implemented
- ex_csr_we_i  in  1  write enable from EX
- ex_csr_waddr_i  in  12  write address
- ex_csr_wdata_i  in  32  final write value; EX resolves RW/RS/RC
- instret_inc_i  in  1  one instruction retired this cycle
- irq_software_i / irq_timer_i / irq_external_i  in  1 each  raw interrupt lines
- cause_type_i  in  1  1 = interrupt, 0 = exception
- set_cause_i  in  1  load mcause
- trap_casue_i  in  4  cause code
- set_mepc_i  in  1  load mepc
- mepc_i  in  32  new mepc
- set_mtval_i  in  1  load mtval
- mtval_i  in  32  new mtval
- mstatus_mie_clear_i  in  1  trap entry
- mstatus_mie_set_i  in  1  mret
- mstatus_mie_o, mie_external_o, mie_timer_o, mie_sw_o  out  1 each  enable bits to ctrl
- mip_external_o, mip_timer_o, mip_sw_o  out  1 each  pending bits to ctrl
- mtvec_o  out  32  trap vector
- mepc_o  out  32  return address

Behaviour:
- Implemented CSRs and addresses:
  - mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305
  - mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344
  - mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82
  - mhartid 0xF14
- Reset (rst=1 at a clk edge): every register is 0 except mtvec={MTVEC_RESET[31:2],2'b00}. All outputs read 0 after reset, except mtvec_o = MTVEC_RESET with bits [1:0] cleared. A reset asserted mid-operation overrides all same-cycle writes and trap commands.
- mstatus:
  - Writable bits: MIE[3] and MPIE[7]. MPP[12:11] always reads 2'b11. All other bits read 0.
- mie:
  - Writable bits: MSIE[3], MTIE[7], MEIE[11]. All other bits read 0.
- mip:
  - Read-only. MSIP[3], MTIP[7], MEIP[11] are the irq inputs registered once, so there is 1 cycle of latency to mip_*_o.
- mtvec:
  - Direct mode only; bits [1:0] are forced 0.
- mepc:
  - Bits [1:0] are forced 0, on both CSR write and trap load.
- mcause:
  - A trap load writes {cause_type_i, 27'b0, trap_casue_i}.
  - A software write stores the full 32 bits.
- mscratch, mtval: full 32-bit read/write.
- misa, mhartid: read-only; writes are silently ignored.
- mcycle:
  - 64-bit counter, +1 every cycle, wraps from 2^64-1 to 0.
  - A write to the low or high half replaces that half for that cycle, with no increment that cycle. The other half holds.
- minstret:
  - 64-bit counter, +instret_inc_i each cycle. Same write rules as mcycle.
- Reads:
  - csr_rdata_o = value at id_csr_raddr_i.
  - Bypass: if ex_csr_we_i=1 and ex_csr_waddr_i==id_csr_raddr_i and the register is writable, csr_rdata_o returns the masked value that will be stored.
  - Unimplemented address: csr_rdata_o=0 and csr_illegal_o=1; a write to it is ignored.
- Trap commands take effect at the next clk edge. Priority per register: rst > trap command > EX write.
- mstatus_mie_clear_i: MPIE<=MIE, MIE<=0.
- mstatus_mie_set_i: MIE<=MPIE, MPIE<=1.
- Clear and set both asserted: clear wins.
- Outputs to ctrl come straight from the registers. There is no combinational path from trap inputs to outputs.

Decomposition:
- CSR address constants (`CsrMstatus ... `CsrMhartid), bit positions (MIE=3, MPIE=7, MEIE=11...) and `CsrRegBus go in the shared defines.v.
- One sub-module: csr_counter64 (64-bit counter with increment enable and per-half write). Instantiated twice, for mcycle and minstret.

Test Plan:
- Reset, then read 0x305 with MTVEC_RESET=32'h80 -> csr_rdata_o=32'h80. Read 0x300 -> 32'h1800. Read 0x7C0 -> rdata 0, csr_illegal_o=1.
- EX writes mstatus=32'h8 and mie=32'h888, then irq_timer_i=1 -> mstatus_mie_o=1, all mie_*_o=1, mip_timer_o=1 one cycle after irq_timer_i rises.
- Trap cycle: mstatus_mie_clear_i, set_cause_i (type 1, code 7), set_mepc_i=32'h103, set_mtval_i=0 -> mcause=32'h80000007, mepc=32'h100, mstatus=32'h1880, mstatus_mie_o=0. Then mstatus_mie_set_i -> mstatus=32'h1888.
- Same-cycle EX write 32'h0 to mstatus together with mstatus_mie_clear_i, starting from MIE=1 -> trap wins: MPIE=1, MIE=0. Same-cycle ID read of 0x340 while EX writes 32'hDEAD_BEEF to 0x340 -> rdata=32'hDEADBEEF.
- Write mcycle=32'hFFFF_FFFF, mcycleh=0 -> next cycle reads mcycle=0, mcycleh=1. Write to misa -> read still MISA_VALUE.
- Hold instret_inc_i=1 for 5 cycles from reset -> minstret=5. Assert rst mid-count -> minstret=0 and mcycle=0 after the edge.
